// File: rtl/sa_tile_ctrl_if.sv
// Signal bundle between the systolic tile sequencer and its scheduler, operand buffers, PE array and writeback.
// The controller takes the master side; the surrounding datapath and bench take the slave side.
interface sa_tile_ctrl_if #(
   parameter int ROWS      = 4,
   parameter int K_BITS    = 16,
   parameter int ADDR_BITS = 12
);
   logic                    start;
   logic                    abort;
   logic [K_BITS-1:0]       k_len;
   logic                    busy;
   logic                    done;
   logic                    op_rd_en;
   logic [ADDR_BITS-1:0]    op_rd_addr;
   logic                    feed_v;
   logic                    pe_clr;
   logic                    pe_shift_en;
   logic                    res_valid;
   logic                    res_ready;
   logic [$clog2(ROWS)-1:0] res_row;

   modport master (
      input  start, abort, k_len, res_ready,
      output busy, done, op_rd_en, op_rd_addr, feed_v, pe_clr, pe_shift_en, res_valid, res_row
   );

   modport slave (
      output start, abort, k_len, res_ready,
      input  busy, done, op_rd_en, op_rd_addr, feed_v, pe_clr, pe_shift_en, res_valid, res_row
   );
endinterface

// File: rtl/sa_tile_ctrl.sv
// Tile job sequencer: clear, feed k_len operand pairs, drain the skew, stream ROWS result rows.
// Latency 1 + k_len + (ROWS+COLS) + ROWS cycles start-to-done; OUT holds each row until res_ready.
module sa_tile_ctrl #(
   parameter int ROWS      = 4,
   parameter int COLS      = 4,
   parameter int K_BITS    = 16,
   parameter int ADDR_BITS = 12
) (
   input  logic           clk,
   input  logic           rst,
   sa_tile_ctrl_if.master bus
);
   localparam int RW = $clog2(ROWS);
   localparam int DW = $clog2(ROWS + COLS);

   typedef enum logic [2:0] {S_IDLE, S_CLR, S_FEED, S_DRAIN, S_OUT} state_t;

   state_t            state_q, state_d;
   logic [K_BITS-1:0] k_reg_q, k_reg_d;
   logic [K_BITS-1:0] k_cnt_q, k_cnt_d;
   logic [DW-1:0]     d_cnt_q, d_cnt_d;
   logic [RW-1:0]     row_cnt_q, row_cnt_d;
   logic              feed_v_q, feed_v_d;
   logic              done_q, done_d;

   logic              op_rd_en;
   logic              pe_clr;
   logic              pe_shift_en;
   logic              res_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         k_reg_q   <= '0;
         k_cnt_q   <= '0;
         d_cnt_q   <= '0;
         row_cnt_q <= '0;
         feed_v_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         k_reg_q   <= k_reg_d;
         k_cnt_q   <= k_cnt_d;
         d_cnt_q   <= d_cnt_d;
         row_cnt_q <= row_cnt_d;
         feed_v_q  <= feed_v_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      k_reg_d     = k_reg_q;
      k_cnt_d     = k_cnt_q;
      d_cnt_d     = d_cnt_q;
      row_cnt_d   = row_cnt_q;
      done_d      = 1'b0;
      op_rd_en    = 1'b0;
      pe_clr      = 1'b0;
      pe_shift_en = 1'b0;
      res_valid   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_CLR;
               k_reg_d = bus.k_len;
            end
         end
         S_CLR: begin
            pe_clr      = 1'b1;
            pe_shift_en = 1'b1;
            // An empty reduction skips straight to readout of the cleared accumulators.
            state_d     = (k_reg_q != '0) ? S_FEED : S_OUT;
         end
         S_FEED: begin
            op_rd_en    = 1'b1;
            pe_shift_en = 1'b1;
            if (k_cnt_q == k_reg_q - K_BITS'(1)) begin
               k_cnt_d = '0;
               state_d = S_DRAIN;
            end else begin
               k_cnt_d = k_cnt_q + K_BITS'(1);
            end
         end
         S_DRAIN: begin
            pe_shift_en = 1'b1;
            if (d_cnt_q == DW'(ROWS + COLS - 1)) begin
               d_cnt_d = '0;
               state_d = S_OUT;
            end else begin
               d_cnt_d = d_cnt_q + DW'(1);
            end
         end
         S_OUT: begin
            res_valid = 1'b1;
            if (bus.res_ready) begin
               if (row_cnt_q == RW'(ROWS - 1)) begin
                  row_cnt_d = '0;
                  state_d   = S_IDLE;
                  done_d    = 1'b1;
               end else begin
                  row_cnt_d = row_cnt_q + RW'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      feed_v_d = op_rd_en;

      // Abort overrides whatever the state decided this cycle.
      if (bus.abort && state_q != S_IDLE) begin
         state_d   = S_IDLE;
         k_reg_d   = '0;
         k_cnt_d   = '0;
         d_cnt_d   = '0;
         row_cnt_d = '0;
         done_d    = 1'b0;
         feed_v_d  = 1'b0;
      end
   end

   assign bus.busy        = (state_q != S_IDLE);
   assign bus.done        = done_q;
   assign bus.op_rd_en    = op_rd_en;
   assign bus.op_rd_addr  = k_cnt_q[ADDR_BITS-1:0];
   assign bus.feed_v      = feed_v_q;
   assign bus.pe_clr      = pe_clr;
   assign bus.pe_shift_en = pe_shift_en;
   assign bus.res_valid   = res_valid;
   assign bus.res_row     = row_cnt_q;
endmodule

// File: tb/tb_sa_tile_ctrl.sv
// Directed bench for sa_tile_ctrl: per-cycle vector table for plain jobs, hand sequences for stalls, abort, start-hold and async reset.
module tb_sa_tile_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;

   sa_tile_ctrl_if #(.ROWS(4), .K_BITS(16), .ADDR_BITS(12)) bus ();

   sa_tile_ctrl #(.ROWS(4), .COLS(4), .K_BITS(16), .ADDR_BITS(12)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        busy;
      logic        done;
      logic        rd;
      logic        fv;
      logic        clr;
      logic        sh;
      logic        rv;
      logic [11:0] addr;
      logic [1:0]  row;
   } out_t;

   typedef struct {
      logic        start;
      logic        abort;
      logic        rdy;
      logic [15:0] k;
      out_t        exp;
   } vec_t;

   vec_t vecs[$];
   int   checks   = 0;
   int   failures = 0;

   function automatic out_t sample();
      out_t o;
      o.busy = bus.busy;
      o.done = bus.done;
      o.rd   = bus.op_rd_en;
      o.fv   = bus.feed_v;
      o.clr  = bus.pe_clr;
      o.sh   = bus.pe_shift_en;
      o.rv   = bus.res_valid;
      o.addr = bus.op_rd_addr;
      o.row  = bus.res_row;
      return o;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic st, input logic ab, input logic rdy, input logic [15:0] k);
      bus.start     = st;
      bus.abort     = ab;
      bus.res_ready = rdy;
      bus.k_len     = k;
   endtask

   // Row: inputs for this cycle, then expected busy,done,rd,fv,clr,sh,rv,addr,row during it.
   function automatic void add(input logic st, input logic ab, input logic rdy, input int k,
                               input logic busy, input logic done, input logic rd, input logic fv,
                               input logic clr, input logic sh, input logic rv,
                               input int addr, input int row);
      vec_t v;
      v.start    = st;
      v.abort    = ab;
      v.rdy      = rdy;
      v.k        = 16'(k);
      v.exp.busy = busy;
      v.exp.done = done;
      v.exp.rd   = rd;
      v.exp.fv   = fv;
      v.exp.clr  = clr;
      v.exp.sh   = sh;
      v.exp.rv   = rv;
      v.exp.addr = 12'(addr);
      v.exp.row  = 2'(row);
      vecs.push_back(v);
   endfunction

   initial begin
      int exp_row;
      int dn;
      int done_at;
      int exp_addr;
      int d_cnt, d1, d2, clr_cnt;
      bit [9:0] patv;

      // T1: k_len=3, res_ready=1
      add(1,0,1,3, 0,0,0,0,0,0,0, 0,0);
      add(0,0,1,0, 1,0,0,0,1,1,0, 0,0);
      add(0,0,1,0, 1,0,1,0,0,1,0, 0,0);
      add(0,0,1,0, 1,0,1,1,0,1,0, 1,0);
      add(0,0,1,0, 1,0,1,1,0,1,0, 2,0);
      add(0,0,1,0, 1,0,0,1,0,1,0, 0,0);
      for (int i = 0; i < 7; i++) add(0,0,1,0, 1,0,0,0,0,1,0, 0,0);
      for (int r = 0; r < 4; r++) add(0,0,1,0, 1,0,0,0,0,0,1, 0,r);
      add(0,0,1,0, 0,1,0,0,0,0,0, 0,0);
      add(0,0,1,0, 0,0,0,0,0,0,0, 0,0);
      // T2: k_len=0 goes CLR -> OUT with no reads
      add(1,0,1,0, 0,0,0,0,0,0,0, 0,0);
      add(0,0,1,0, 1,0,0,0,1,1,0, 0,0);
      for (int r = 0; r < 4; r++) add(0,0,1,0, 1,0,0,0,0,0,1, 0,r);
      add(0,0,1,0, 0,1,0,0,0,0,0, 0,0);
      add(0,0,1,0, 0,0,0,0,0,0,0, 0,0);

      drive(0, 0, 0, 16'd0);
      #1;
      check("reset_outputs", 32'(sample()), 32'(out_t'('0)));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         @(negedge clk);
         check($sformatf("vec%0d", i), 32'(sample()), 32'(vecs[i].exp));
         drive(vecs[i].start, vecs[i].abort, vecs[i].rdy, vecs[i].k);
      end

      // T3: res_ready stalls during OUT
      @(negedge clk);
      drive(1, 0, 0, 16'd1);
      @(negedge clk);
      bus.start = 1'b0;
      for (int n = 0; n < 50 && !bus.res_valid; n++) @(negedge clk);
      check("t3_reach_out", 32'(bus.res_valid), 32'd1);
      patv    = 10'b1001001001;
      exp_row = 0;
      for (int i = 0; i < 10; i++) begin
         check($sformatf("t3_valid%0d", i), 32'(bus.res_valid), 32'd1);
         check($sformatf("t3_row%0d", i), 32'(bus.res_row), 32'(exp_row));
         check($sformatf("t3_shift%0d", i), 32'(bus.pe_shift_en), 32'd0);
         bus.res_ready = patv[i];
         @(negedge clk);
         if (patv[i]) exp_row++;
      end
      check("t3_done", 32'(bus.done), 32'd1);
      check("t3_idle", 32'(bus.busy), 32'd0);
      bus.res_ready = 1'b1;

      // T4: abort in the second FEED cycle, then a clean rerun
      @(negedge clk);
      drive(1, 0, 1, 16'd8);
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("t4_feed2_addr", 32'(bus.op_rd_addr), 32'd1);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      check("t4_abort_busy", 32'(bus.busy), 32'd0);
      check("t4_abort_fv", 32'(bus.feed_v), 32'd0);
      check("t4_abort_rd", 32'(bus.op_rd_en), 32'd0);
      check("t4_abort_sh", 32'(bus.pe_shift_en), 32'd0);
      dn = 0;
      for (int i = 0; i < 5; i++) begin
         if (bus.done) dn++;
         @(negedge clk);
      end
      check("t4_no_done", 32'(dn), 32'd0);
      drive(1, 0, 1, 16'd8);
      done_at  = 0;
      exp_addr = 0;
      for (int c = 1; c <= 60 && done_at == 0; c++) begin
         @(negedge clk);
         bus.start = 1'b0;
         if (bus.op_rd_en) begin
            check($sformatf("t4_addr%0d", exp_addr), 32'(bus.op_rd_addr), 32'(exp_addr));
            exp_addr++;
         end
         if (bus.done) done_at = c;
      end
      check("t4_reads", 32'(exp_addr), 32'd8);
      check("t4_done_cycle", 32'(done_at), 32'd22);

      // T5: start held high across a whole job
      d_cnt = 0; d1 = 0; d2 = 0; clr_cnt = 0;
      for (int c = 0; c <= 40; c++) begin
         @(negedge clk);
         if (bus.done) begin
            d_cnt++;
            if (d_cnt == 1) d1 = c;
            if (d_cnt == 2) d2 = c;
         end
         if (bus.pe_clr) clr_cnt++;
         drive(c <= 16, 0, 1, 16'd2);
      end
      check("t5_done_count", 32'(d_cnt), 32'd2);
      check("t5_done1", 32'(d1), 32'd16);
      check("t5_done2", 32'(d2), 32'd32);
      check("t5_jobs", 32'(clr_cnt), 32'd2);
      check("t5_idle", 32'(bus.busy), 32'd0);

      // T6: async reset in the middle of DRAIN
      @(negedge clk);
      drive(1, 0, 1, 16'd1);
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("t6_in_drain", 32'({bus.busy, bus.pe_shift_en, bus.op_rd_en}), 32'b110);
      rst = 1'b1;
      #1;
      check("t6_async", 32'(sample()), 32'(out_t'('0)));
      @(negedge clk);
      check("t6_held", 32'(sample()), 32'(out_t'('0)));
      rst = 1'b0;
      dn = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.done || bus.busy) dn++;
      end
      check("t6_stays_idle", 32'(dn), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
